// File: rtl/present_pkg.sv
// Shared constants, state type and S-box for the PRESENT-80 key schedule.
package present_pkg;
  localparam int KEY_W  = 80;
  localparam int RK_W   = 64;
  localparam int NUM_RK = 32;
  localparam logic [5:0] LAST_ROUND = 6'(NUM_RK);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction
endpackage

// File: rtl/present_key_sched_ctrl_keyfun.sv
// Combinational PRESENT-80 key update: rotate left 61, S-box top nibble, XOR round counter.
module PresentKeyFun
  import present_pkg::*;
(
  input  logic [KEY_W-1:0] inKey,
  input  logic [4:0]       inCnt,
  output logic [KEY_W-1:0] outKey
);

  logic [KEY_W-1:0] w_rot;

  assign w_rot  = {inKey[18:0], inKey[79:19]};
  assign outKey = {present_sbox(w_rot[79:76]), w_rot[75:20], w_rot[19:15] ^ inCnt, w_rot[14:0]};

endmodule

// File: rtl/present_key_sched_ctrl.sv
// Key-schedule sequencer: loads the user key and streams K1..K32 over valid/ready.
module present_key_sched_ctrl
  import present_pkg::*;
(
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inStart,
  input  logic [KEY_W-1:0] inKey,
  input  logic             inAbort,
  input  logic             inReady,
  output logic             outValid,
  output logic [RK_W-1:0]  outRoundKey,
  output logic [5:0]       outRoundIdx,
  output logic             outBusy,
  output logic             outDone
);

  state_t           r_state;
  logic [KEY_W-1:0] r_key;
  logic [5:0]       r_cnt;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;
  logic [KEY_W-1:0] w_key_next;

  PresentKeyFun u_keyfun (
    .inKey  (r_key),
    .inCnt  (r_cnt[4:0]),
    .outKey (w_key_next)
  );

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_cnt   <= 6'd1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (inStart) begin
            r_key   <= inKey;
            r_cnt   <= 6'd1;
            r_state <= RUN;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          // Abort wins over a same-cycle handshake; the pending key update is dropped.
          if (inAbort) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (inReady) begin
            if (r_cnt == LAST_ROUND) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_key <= w_key_next;
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign outValid    = r_valid;
  assign outBusy     = r_busy;
  assign outDone     = r_done;
  assign outRoundKey = r_key[79:16];
  assign outRoundIdx = r_cnt;

endmodule

// File: tb/tb_present_key_sched_ctrl.sv
// Directed bench for present_key_sched_ctrl: known round keys, cipher known answers, handshake corners.
module tb_present_key_sched_ctrl;

  logic        inClk;
  logic        inRstN;
  logic        inStart;
  logic [79:0] inKey;
  logic        inAbort;
  logic        inReady;
  logic        outValid;
  logic [63:0] outRoundKey;
  logic [5:0]  outRoundIdx;
  logic        outBusy;
  logic        outDone;

  int n_total;
  int n_bad;

  logic [63:0] exp_rk [1:32];
  logic [63:0] rk_got [1:32];

  present_key_sched_ctrl dut (
    .inClk       (inClk),
    .inRstN      (inRstN),
    .inStart     (inStart),
    .inKey       (inKey),
    .inAbort     (inAbort),
    .inReady     (inReady),
    .outValid    (outValid),
    .outRoundKey (outRoundKey),
    .outRoundIdx (outRoundIdx),
    .outBusy     (outBusy),
    .outDone     (outDone)
  );

  initial inClk = 1'b0;
  always #5 inClk = ~inClk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] tb_sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21E7_4F3D_A09B_65C0 ;
    // nibble n of tbl holds S(n): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
    tbl = {4'h2, 4'h1, 4'h7, 4'h4, 4'h8, 4'hF, 4'hE, 4'h3,
           4'hD, 4'hA, 4'h0, 4'h9, 4'hB, 4'h6, 4'h5, 4'hC};
    return tbl[x*4 +: 4];
  endfunction

  task automatic model_sched(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_rk[1] = k[79:16];
    for (int i = 1; i < 32; i++) begin
      k = (k << 61) | (k >> 19);
      k[79:76] = tb_sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(i);
      exp_rk[i+1] = k[79:16];
    end
  endtask

  function automatic logic [63:0] present_enc(input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] ns;
    s = pt;
    for (int r = 1; r < 32; r++) begin
      s = s ^ rk_got[r];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = tb_sbox(s[n*4 +: 4]);
      ns = '0;
      for (int j = 0; j < 63; j++) ns[(j*16) % 63] = s[j];
      ns[63] = s[63];
      s = ns;
    end
    return s ^ rk_got[32];
  endfunction

  // Called at a negedge in IDLE; returns at the negedge where K1 should be visible.
  task automatic do_start(input logic [79:0] key);
    inStart = 1'b1;
    inKey   = key;
    @(negedge inClk);
    inStart = 1'b0;
  endtask

  task automatic run_sched(input string name, input logic [79:0] key, input int ready_pct,
                           input int rogue_idx, input bit chain, input logic [79:0] next_key);
    int          hs;
    int          cyc;
    bit          prev_stall;
    logic [63:0] prev_key;
    logic [5:0]  prev_idx;
    model_sched(key);
    hs = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_key = '0;
    prev_idx = '0;
    while (hs < 32 && cyc < 400) begin
      chk({name, "_valid"}, 80'(outValid), 80'd1);
      chk({name, "_busy"}, 80'(outBusy), 80'd1);
      if (prev_stall) begin
        chk({name, "_stall_key"}, 80'(outRoundKey), 80'(prev_key));
        chk({name, "_stall_idx"}, 80'(outRoundIdx), 80'(prev_idx));
      end
      chk({name, "_idx"}, 80'(outRoundIdx), 80'(hs + 1));
      chk({name, "_rk"}, 80'(outRoundKey), 80'(exp_rk[hs+1]));
      inReady = ($urandom_range(99) < ready_pct);
      inStart = (hs + 1 == rogue_idx);
      inKey   = inStart ? ~key : key;
      prev_key = outRoundKey;
      prev_idx = outRoundIdx;
      prev_stall = !inReady;
      if (inReady) begin
        rk_got[hs+1] = outRoundKey;
        hs++;
      end
      @(negedge inClk);
      cyc++;
    end
    chk({name, "_handshakes"}, 80'(hs), 80'd32);
    inReady = 1'b0;
    inStart = 1'b0;
    chk({name, "_done_pulse"}, 80'(outDone), 80'd1);
    chk({name, "_done_valid"}, 80'(outValid), 80'd0);
    chk({name, "_done_busy"}, 80'(outBusy), 80'd0);
    $display("run %s: key=%020h handshakes=%0d cycles=%0d", name, key, hs, cyc);
    if (chain) begin
      do_start(next_key);
    end else begin
      @(negedge inClk);
      chk({name, "_done_once"}, 80'(outDone), 80'd0);
    end
  endtask

  initial begin
    logic [79:0] rkey;
    n_total = 0;
    n_bad   = 0;
    inRstN  = 1'b0;
    inStart = 1'b0;
    inKey   = '0;
    inAbort = 1'b0;
    inReady = 1'b0;
    repeat (2) @(negedge inClk);
    chk("rst_valid", 80'(outValid), 80'd0);
    chk("rst_busy", 80'(outBusy), 80'd0);
    chk("rst_done", 80'(outDone), 80'd0);
    chk("rst_rk", 80'(outRoundKey), 80'd0);
    chk("rst_idx", 80'(outRoundIdx), 80'd1);
    inRstN = 1'b1;
    @(negedge inClk);

    // Key 0: hand-checked K1..K3 and the cipher known answer.
    do_start(80'h0);
    run_sched("zero", 80'h0, 100, 0, 1'b0, 80'h0);
    chk("zero_k1", 80'(rk_got[1]), 80'h0);
    chk("zero_k2", 80'(rk_got[2]), 80'hC000_0000_0000_0000);
    chk("zero_k3", 80'(rk_got[3]), 80'h5000_1800_0000_0001);
    chk("zero_enc", 80'(present_enc(64'h0)), 80'h5579_C138_7B22_8445);

    do_start({80{1'b1}});
    run_sched("ones", {80{1'b1}}, 100, 0, 1'b0, 80'h0);
    chk("ones_enc", 80'(present_enc(64'h0)), 80'hE72C_46C0_F594_5049);

    rkey = {$urandom, $urandom, 16'($urandom)};
    do_start(rkey);
    run_sched("rand", rkey, 100, 0, 1'b0, 80'h0);
    do_start(rkey);
    run_sched("bp", rkey, 50, 0, 1'b0, 80'h0);

    // Start during RUN is ignored; start in the done cycle chains straight into K1.
    do_start(80'h0123_4567_89AB_CDEF_1357);
    run_sched("rogue", 80'h0123_4567_89AB_CDEF_1357, 100, 5, 1'b1, 80'hFEDC_BA98_7654_3210_ACE0);
    run_sched("chain", 80'hFEDC_BA98_7654_3210_ACE0, 100, 0, 1'b0, 80'h0);

    // Abort at index 10 with ready asserted.
    do_start(80'hA5A5_5A5A_A5A5_5A5A_A5A5);
    inReady = 1'b1;
    for (int i = 0; i < 40 && outRoundIdx != 6'd10; i++) @(negedge inClk);
    chk("abort_at_idx", 80'(outRoundIdx), 80'd10);
    inAbort = 1'b1;
    @(negedge inClk);
    inAbort = 1'b0;
    inReady = 1'b0;
    chk("abort_valid", 80'(outValid), 80'd0);
    chk("abort_busy", 80'(outBusy), 80'd0);
    chk("abort_done", 80'(outDone), 80'd0);
    @(negedge inClk);
    chk("abort_no_done", 80'(outDone), 80'd0);
    chk("abort_idle", 80'(outValid), 80'd0);
    $display("run abort: stopped at idx 10");
    do_start(80'h1111_2222_3333_4444_5555);
    chk("restart_idx", 80'(outRoundIdx), 80'd1);
    chk("restart_k1", 80'(outRoundKey), 80'h1111_2222_3333_4444);
    run_sched("restart", 80'h1111_2222_3333_4444_5555, 100, 0, 1'b0, 80'h0);

    // Asynchronous reset between clock edges in the middle of a run.
    do_start(80'h0F0F_0F0F_0F0F_0F0F_0F0F);
    inReady = 1'b1;
    repeat (4) @(negedge inClk);
    @(posedge inClk);
    #2;
    inRstN = 1'b0;
    #1;
    chk("arst_valid", 80'(outValid), 80'd0);
    chk("arst_busy", 80'(outBusy), 80'd0);
    chk("arst_done", 80'(outDone), 80'd0);
    chk("arst_rk", 80'(outRoundKey), 80'd0);
    chk("arst_idx", 80'(outRoundIdx), 80'd1);
    @(negedge inClk);
    inReady = 1'b0;
    inRstN  = 1'b1;
    repeat (2) @(negedge inClk);
    chk("arst_idle_valid", 80'(outValid), 80'd0);
    chk("arst_idle_busy", 80'(outBusy), 80'd0);
    $display("run arst: reset asserted mid-run");
    do_start(80'h0);
    run_sched("post_rst", 80'h0, 100, 0, 1'b0, 80'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
